// File: rtl/quad_decoder_if.sv
// Signal bundle between the quadrature decoder and its environment.
// master drives the filtered encoder channels and clear; slave is the decoder.
interface quad_decoder_if #(
  parameter int unsigned Width    = 16,
  parameter int unsigned ErrWidth = 8
);
  logic                a;
  logic                b;
  logic                index;
  logic                clear;
  logic [Width-1:0]    position;
  logic                direction;
  logic                step;
  logic                error;
  logic [ErrWidth-1:0] err_count;
  logic [Width-1:0]    index_position;

  modport master (
    output a, b, index, clear,
    input  position, direction, step, error, err_count, index_position
  );

  modport slave (
    input  a, b, index, clear,
    output position, direction, step, error, err_count, index_position
  );
endinterface

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: signed wrapping position, direction, step strobe, illegal-jump detect.
// Optional index latch of the position on Index rising edge, enabled by QUAD_INDEX_LATCH_EN.
module quad_decoder #(
  parameter int unsigned Width    = 16,
  parameter int unsigned ErrWidth = 8
) (
  input logic          Clock,
  input logic          Reset_n,
  quad_decoder_if.slave qif
);

  localparam logic [Width-1:0]    PosOne = Width'(1);
  localparam logic [ErrWidth-1:0] ErrOne = ErrWidth'(1);

  logic                primed_q, primed_d;
  logic [1:0]          prev_ab_q, prev_ab_d;
  logic [Width-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                step_q, step_d;
  logic                err_q, err_d;
  logic [ErrWidth-1:0] cnt_q, cnt_d;
  logic [1:0]          ab;
  logic                fwd, bwd, illegal;

  // Forward Gray order: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] gray_next(input logic [1:0] s);
    unique case (s)
      2'b00:   gray_next = 2'b01;
      2'b01:   gray_next = 2'b11;
      2'b11:   gray_next = 2'b10;
      default: gray_next = 2'b00;
    endcase
  endfunction

  assign ab      = {qif.a, qif.b};
  assign fwd     = (ab == gray_next(prev_ab_q));
  assign bwd     = (prev_ab_q == gray_next(ab));
  assign illegal = ((ab ^ prev_ab_q) == 2'b11);

  always_comb begin
    primed_d  = 1'b1;
    prev_ab_d = ab;
    pos_d     = pos_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    err_d     = err_q;
    cnt_d     = cnt_q;
    if (qif.clear) begin
      pos_d = '0;
      err_d = 1'b0;
      cnt_d = '0;
    end else if (primed_q) begin
      if (fwd) begin
        pos_d  = pos_q + PosOne;
        dir_d  = 1'b1;
        step_d = 1'b1;
      end else if (bwd) begin
        pos_d  = pos_q - PosOne;
        dir_d  = 1'b0;
        step_d = 1'b1;
      end else if (illegal) begin
        err_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + ErrOne;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      primed_q  <= 1'b0;
      prev_ab_q <= 2'b00;
      pos_q     <= '0;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      primed_q  <= primed_d;
      prev_ab_q <= prev_ab_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign qif.position  = pos_q;
  assign qif.direction = dir_q;
  assign qif.step      = step_q;
  assign qif.error     = err_q;
  assign qif.err_count = cnt_q;

`ifdef QUAD_INDEX_LATCH_EN
  logic             prev_index_q, prev_index_d;
  logic [Width-1:0] idx_pos_q, idx_pos_d;

  // Edge detect only runs once primed, so Index high at reset release still latches once.
  always_comb begin
    prev_index_d = prev_index_q;
    idx_pos_d    = idx_pos_q;
    if (primed_q) begin
      prev_index_d = qif.index;
      if (qif.index && !prev_index_q) idx_pos_d = pos_d;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_index_q <= 1'b0;
      idx_pos_q    <= '0;
    end else begin
      prev_index_q <= prev_index_d;
      idx_pos_q    <= idx_pos_d;
    end
  end

  assign qif.index_position = idx_pos_q;
`else
  logic unused_index;
  assign unused_index       = qif.index;
  assign qif.index_position = '0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: 16-bit instance for main behaviour, 4-bit instance for wrap.
module tb_quad_decoder;

  logic Clock;
  logic Reset_n;
  int   n_total;
  int   n_bad;

  quad_decoder_if #(.Width(16), .ErrWidth(8)) qif ();
  quad_decoder_if #(.Width(4),  .ErrWidth(8)) q4 ();

  quad_decoder #(.Width(16), .ErrWidth(8)) u_dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .qif     (qif)
  );

  quad_decoder #(.Width(4), .ErrWidth(8)) u_dut4 (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .qif     (q4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] ab);
    {qif.a, qif.b} = ab;
    tick();
  endtask

  task automatic drive4(input logic [1:0] ab);
    {q4.a, q4.b} = ab;
    tick();
  endtask

  logic [1:0] fwd_seq [4];
  logic [1:0] bwd_seq [4];
  logic [15:0] exp_idx;
  int pulses;

  initial begin
    n_total = 0;
    n_bad   = 0;
    fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    bwd_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    qif.a = 1'b1; qif.b = 1'b1; qif.index = 1'b0; qif.clear = 1'b0;
    q4.a  = 1'b0; q4.b  = 1'b0; q4.index  = 1'b0; q4.clear  = 1'b0;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    check_eq("rst_pos", 32'(qif.position), 32'h0);
    check_eq("rst_dir", 32'(qif.direction), 32'h1);
    check_eq("rst_step", 32'(qif.step), 32'h0);
    check_eq("rst_err", 32'(qif.error), 32'h0);
    check_eq("rst_cnt", 32'(qif.err_count), 32'h0);
    check_eq("rst_idx", 32'(qif.index_position), 32'h0);
    tick();
    Reset_n = 1'b1;

    // AB=11 out of reset must not produce a step
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (qif.step) pulses++;
    end
    check_eq("prime_steps", 32'(pulses), 32'h0);
    check_eq("prime_pos", 32'(qif.position), 32'h0);
    check_eq("prime_err", 32'(qif.error), 32'h0);

    // 11 -> 00 is illegal, but clear wins
    qif.clear = 1'b1;
    drive(2'b00);
    qif.clear = 1'b0;
    check_eq("clr_absorb_err", 32'(qif.error), 32'h0);
    check_eq("clr_absorb_pos", 32'(qif.position), 32'h0);

    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      drive(fwd_seq[i % 4]);
      if (qif.step) pulses++;
      check_eq("fwd_pos", 32'(qif.position), 32'(i + 1));
    end
    check_eq("fwd_pulses", 32'(pulses), 32'd12);
    check_eq("fwd_dir", 32'(qif.direction), 32'h1);
    drive(2'b00);
    check_eq("idle_step", 32'(qif.step), 32'h0);
    check_eq("idle_pos", 32'(qif.position), 32'd12);

    for (int i = 0; i < 16; i++) begin
      drive(bwd_seq[i % 4]);
      check_eq("bwd_step", 32'(qif.step), 32'h1);
    end
    check_eq("bwd_pos", 32'(qif.position), 32'h0000fffc);
    check_eq("bwd_dir", 32'(qif.direction), 32'h0);

    drive(2'b11);
    check_eq("ill1_err", 32'(qif.error), 32'h1);
    check_eq("ill1_cnt", 32'(qif.err_count), 32'h1);
    check_eq("ill1_pos", 32'(qif.position), 32'h0000fffc);
    check_eq("ill1_step", 32'(qif.step), 32'h0);
    drive(2'b01);
    check_eq("back_pos", 32'(qif.position), 32'h0000fffb);
    drive(2'b10);
    check_eq("ill2_cnt", 32'(qif.err_count), 32'h2);
    check_eq("ill2_pos", 32'(qif.position), 32'h0000fffb);
    check_eq("ill2_dir", 32'(qif.direction), 32'h0);

    qif.clear = 1'b1;
    drive(2'b00);
    qif.clear = 1'b0;
    check_eq("clr_pos", 32'(qif.position), 32'h0);
    check_eq("clr_err", 32'(qif.error), 32'h0);
    check_eq("clr_cnt", 32'(qif.err_count), 32'h0);
    check_eq("clr_step", 32'(qif.step), 32'h0);
    check_eq("clr_dir", 32'(qif.direction), 32'h0);

    for (int i = 0; i < 260; i++) drive((i % 2 == 0) ? 2'b11 : 2'b00);
    check_eq("sat_cnt", 32'(qif.err_count), 32'hff);
    check_eq("sat_err", 32'(qif.error), 32'h1);
    qif.clear = 1'b1;
    drive(2'b00);
    qif.clear = 1'b0;
    check_eq("sat_clr", 32'(qif.err_count), 32'h0);

    for (int i = 0; i < 37; i++) drive(fwd_seq[i % 4]);
    check_eq("idx_pre_pos", 32'(qif.position), 32'd37);
`ifdef QUAD_INDEX_LATCH_EN
    exp_idx = 16'd38;
`else
    exp_idx = 16'd0;
`endif
    qif.index = 1'b1;
    drive(fwd_seq[1]);
    check_eq("idx_pos", 32'(qif.position), 32'd38);
    check_eq("idx_latch", 32'(qif.index_position), 32'(exp_idx));
    drive(fwd_seq[2]);
    check_eq("idx_hold", 32'(qif.index_position), 32'(exp_idx));
    qif.index = 1'b0;
    drive(fwd_seq[2]);
    qif.index = 1'b1;
    qif.clear = 1'b1;
    drive(fwd_seq[2]);
    qif.clear = 1'b0;
    qif.index = 1'b0;
    check_eq("idx_clr", 32'(qif.index_position), 32'h0);

    // async reset mid-operation, with AB=11 held across release
    drive(fwd_seq[3]);
    drive(fwd_seq[0]);
    {qif.a, qif.b} = 2'b11;
    Reset_n = 1'b0;
    #1;
    check_eq("mid_rst_pos", 32'(qif.position), 32'h0);
    check_eq("mid_rst_dir", 32'(qif.direction), 32'h1);
    tick();
    Reset_n = 1'b1;
    tick();
    tick();
    check_eq("reprime_step", 32'(qif.step), 32'h0);
    check_eq("reprime_pos", 32'(qif.position), 32'h0);

    for (int i = 0; i < 7; i++) drive4(fwd_seq[i % 4]);
    check_eq("w4_pos7", 32'(q4.position), 32'h7);
    drive4(fwd_seq[3]);
    check_eq("w4_wrap_up", 32'(q4.position), 32'h8);
    q4.clear = 1'b1;
    drive4(fwd_seq[0]);
    q4.clear = 1'b0;
    check_eq("w4_clr", 32'(q4.position), 32'h0);
    drive4(2'b00);
    check_eq("w4_wrap_dn", 32'(q4.position), 32'hf);
    check_eq("w4_dir", 32'(q4.direction), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
